// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, cache-miss waits, mispredict flushes.
// Optional HAZARD_PERF_EN adds saturating load-use, D-miss and flush counters.
module hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_uses_rt,
    input  logic       EX_mem_read,
    input  logic [4:0] EX_dest_reg,
    input  logic       EX_mispredict,
    input  logic       icache_miss,
    input  logic       icache_ready,
    input  logic       dcache_miss,
    input  logic       dcache_ready,
    output logic       PC_write,
    output logic       IF_ID_write,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       EX_MEM_write,
    output logic       MEM_WB_flush,
    output logic       miss_timeout_err,
    output logic [1:0] state_dbg
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_loaduse_cyc,
    output logic [CNT_W-1:0] perf_dmiss_cyc,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    localparam int WAIT_W = (MISS_TIMEOUT < 1) ? 1 : $clog2(MISS_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        DC_WAIT    = 2'b01,
        IC_WAIT    = 2'b10,
        FLUSH_PEND = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic              pend_flush, pend_nxt;
    logic              ic_pend, icp_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_inc;
    logic              in_wait;
    logic              load_use;

    assign load_use = EX_mem_read && (EX_dest_reg != 5'd0) &&
                      ((EX_dest_reg == ID_rs) ||
                       (ID_uses_rt && (EX_dest_reg == ID_rt)));

    assign in_wait   = (state == DC_WAIT) || (state == IC_WAIT);
    assign wait_inc  = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
    assign state_dbg = state;

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_write = 1'b1;
        MEM_WB_flush = 1'b0;
        state_nxt    = state;
        pend_nxt     = pend_flush;
        icp_nxt      = ic_pend;

        unique case (state)
            RUN: begin
                if (dcache_miss) begin
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    EX_MEM_write = 1'b0;
                    MEM_WB_flush = 1'b1;
                    state_nxt    = DC_WAIT;
                    pend_nxt     = EX_mispredict;
                    icp_nxt      = 1'b0;
                end else if (EX_mispredict) begin
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (icache_miss) begin
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    ID_EX_flush = 1'b1;
                    state_nxt   = IC_WAIT;
                end else if (load_use) begin
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    ID_EX_flush = 1'b1;
                end
            end
            DC_WAIT: begin
                if (EX_mispredict)
                    pend_nxt = 1'b1;
                if (ic_pend && icache_ready)
                    icp_nxt = 1'b0;
                if (dcache_ready) begin
                    icp_nxt = 1'b0;
                    if (pend_flush || EX_mispredict) begin
                        state_nxt = FLUSH_PEND;
                    end else if (ic_pend && !icache_ready) begin
                        // I-miss still outstanding: front end stays parked
                        PC_write    = 1'b0;
                        IF_ID_write = 1'b0;
                        ID_EX_flush = 1'b1;
                        state_nxt   = IC_WAIT;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    EX_MEM_write = 1'b0;
                    MEM_WB_flush = 1'b1;
                end
            end
            IC_WAIT: begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
                if (dcache_miss) begin
                    ID_EX_flush  = 1'b0;
                    EX_MEM_write = 1'b0;
                    MEM_WB_flush = 1'b1;
                    state_nxt    = DC_WAIT;
                    icp_nxt      = !icache_ready;
                    pend_nxt     = EX_mispredict;
                end else if (EX_mispredict) begin
                    IF_ID_flush = 1'b1;
                    PC_write    = 1'b1;
                end else if (icache_ready) begin
                    PC_write    = 1'b1;
                    IF_ID_write = 1'b1;
                    ID_EX_flush = 1'b0;
                    state_nxt   = RUN;
                end
            end
            FLUSH_PEND: begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                pend_nxt    = 1'b0;
                state_nxt   = RUN;
            end
            default: state_nxt = RUN;
        endcase

        if (rst) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_write = 1'b1;
            MEM_WB_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            pend_flush       <= 1'b0;
            ic_pend          <= 1'b0;
            wait_cnt         <= '0;
            miss_timeout_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend_flush <= pend_nxt;
            ic_pend    <= icp_nxt;
            if (in_wait && (state_nxt == state))
                wait_cnt <= wait_inc;
            else
                wait_cnt <= '0;
            if (in_wait && (MISS_TIMEOUT != 0) &&
                (wait_inc >= WAIT_W'(MISS_TIMEOUT)))
                miss_timeout_err <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_ev, flush_ev;

    assign lu_ev = (state == RUN) && !dcache_miss && !EX_mispredict &&
                   !icache_miss && load_use;
    assign flush_ev = (state == FLUSH_PEND) ||
                      (((state == RUN) || (state == IC_WAIT)) &&
                       !dcache_miss && EX_mispredict);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loaduse_cyc <= '0;
            perf_dmiss_cyc   <= '0;
            perf_flush_cnt   <= '0;
        end else begin
            if (lu_ev && (perf_loaduse_cyc != '1))
                perf_loaduse_cyc <= perf_loaduse_cyc + 1'b1;
            if ((state == DC_WAIT) && (perf_dmiss_cyc != '1))
                perf_dmiss_cyc <= perf_dmiss_cyc + 1'b1;
            if (flush_ev && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (built with MISS_TIMEOUT=4).
// Control outputs are packed {PC_w, IFID_w, IFID_f, IDEX_f, EXMEM_w, MEMWB_f}.
module tb_hazard_ctrl;

    localparam logic [5:0] DEF   = 6'b110010;
    localparam logic [5:0] RSTV  = 6'b001111;
    localparam logic [5:0] STALL = 6'b000110;
    localparam logic [5:0] FRZ   = 6'b000001;
    localparam logic [5:0] MISP  = 6'b111110;
    localparam logic [5:0] ICMP  = 6'b101110;

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_DC  = 2'b01;
    localparam logic [1:0] S_IC  = 2'b10;
    localparam logic [1:0] S_FP  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EX_dest_reg;
    logic       ID_uses_rt, EX_mem_read, EX_mispredict;
    logic       icache_miss, icache_ready, dcache_miss, dcache_ready;
    logic       PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush;
    logic       EX_MEM_write, MEM_WB_flush, miss_timeout_err;
    logic [1:0] state_dbg;
    logic [5:0] ctl;
`ifdef HAZARD_PERF_EN
    logic [15:0] perf_loaduse_cyc, perf_dmiss_cyc, perf_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    assign ctl = {PC_write, IF_ID_write, IF_ID_flush,
                  ID_EX_flush, EX_MEM_write, MEM_WB_flush};

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16), .MISS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .EX_mem_read(EX_mem_read), .EX_dest_reg(EX_dest_reg),
        .EX_mispredict(EX_mispredict),
        .icache_miss(icache_miss), .icache_ready(icache_ready),
        .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_write(EX_MEM_write), .MEM_WB_flush(MEM_WB_flush),
        .miss_timeout_err(miss_timeout_err), .state_dbg(state_dbg)
`ifdef HAZARD_PERF_EN
        ,
        .perf_loaduse_cyc(perf_loaduse_cyc),
        .perf_dmiss_cyc(perf_dmiss_cyc),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic idle();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0;
        EX_mem_read = 1'b0; EX_dest_reg = 5'd0; EX_mispredict = 1'b0;
        icache_miss = 1'b0; icache_ready = 1'b0;
        dcache_miss = 1'b0; dcache_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp_ctl,
                       input logic [1:0] exp_st);
        #1;
        checks++;
        assert (ctl === exp_ctl) else begin
            failures++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, ctl, exp_ctl);
        end
        checks++;
        assert (state_dbg === exp_st) else begin
            failures++;
            $error("FAIL %s state observed=%b expected=%b", tag, state_dbg, exp_st);
        end
    endtask

    task automatic chk_err(input string tag, input logic exp_e);
        checks++;
        assert (miss_timeout_err === exp_e) else begin
            failures++;
            $error("FAIL %s err observed=%b expected=%b", tag, miss_timeout_err, exp_e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        chk("rst_cycle", RSTV, state_dbg);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        chk("rst_out", RSTV, 2'bxx === 2'bxx ? state_dbg : S_RUN);
        tick();
        rst = 1'b0;
        chk("post_rst", DEF, S_RUN);
        chk_err("post_rst", 1'b0);
        tick();

        // load-use on rs, on rt, then non-hazard variants
        EX_mem_read = 1'b1; EX_dest_reg = 5'd5; ID_rs = 5'd5;
        chk("lu_rs", STALL, S_RUN);
        tick();
        idle();
        chk("lu_after", DEF, S_RUN);
        tick();
        EX_mem_read = 1'b1; EX_dest_reg = 5'd7; ID_rs = 5'd1;
        ID_rt = 5'd7; ID_uses_rt = 1'b1;
        chk("lu_rt", STALL, S_RUN);
        ID_uses_rt = 1'b0;
        chk("lu_rt_unused", DEF, S_RUN);
        EX_dest_reg = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b1;
        chk("lu_r0", DEF, S_RUN);
        EX_mem_read = 1'b0; EX_dest_reg = 5'd3; ID_rs = 5'd3;
        chk("no_load", DEF, S_RUN);
        tick();
        idle();

        // timeout: miss held 6 cycles, error after 4th wait cycle
        dcache_miss = 1'b1;
        chk("to_c0", FRZ, S_RUN);
        tick();
        for (int i = 1; i <= 5; i++) begin
            chk("to_wait", FRZ, S_DC);
            chk_err("to_wait", (i >= 5));
            tick();
        end
        dcache_miss = 1'b0; dcache_ready = 1'b1;
        chk("to_ready", DEF, S_DC);
        chk_err("to_ready", 1'b1);
        tick();
        idle();
        chk("to_run", DEF, S_RUN);
        chk_err("to_sticky", 1'b1);
        tick();
        do_reset();
        chk("to_clr", DEF, S_RUN);
        chk_err("to_clr", 1'b0);
        tick();

        // D-miss for 10 cycles, ready pulse, back to RUN
        for (int i = 1; i <= 10; i++) begin
            dcache_miss = 1'b1;
            chk("dm_wait", FRZ, (i == 1) ? S_RUN : S_DC);
            tick();
        end
        dcache_miss = 1'b0; dcache_ready = 1'b1;
        chk("dm_ready", DEF, S_DC);
        tick();
        idle();
        chk("dm_run", DEF, S_RUN);
`ifdef HAZARD_PERF_EN
        checks++;
        assert (perf_dmiss_cyc === 16'd10) else begin
            failures++;
            $error("FAIL perf_dmiss observed=%0d expected=10", perf_dmiss_cyc);
        end
`endif
        tick();

        // mispredict on 3rd wait cycle -> one FLUSH_PEND cycle after ready
        dcache_miss = 1'b1;
        chk("mdm_c1", FRZ, S_RUN);
        tick();
        chk("mdm_w1", FRZ, S_DC);
        tick();
        chk("mdm_w2", FRZ, S_DC);
        tick();
        EX_mispredict = 1'b1;
        chk("mdm_w3", FRZ, S_DC);
        tick();
        EX_mispredict = 1'b0;
        tick();
        tick();
        dcache_miss = 1'b0; dcache_ready = 1'b1;
        chk("mdm_ready", DEF, S_DC);
        tick();
        idle();
        chk("mdm_fp", MISP, S_FP);
        tick();
        chk("mdm_run", DEF, S_RUN);
        tick();

        // I-miss at t0, D-miss at t2, D-ready at t6, I-ready at t9
        icache_miss = 1'b1;
        chk("id_t0", STALL, S_RUN);
        tick();
        chk("id_t1", STALL, S_IC);
        tick();
        dcache_miss = 1'b1;
        chk("id_t2", FRZ, S_IC);
        tick();
        for (int i = 3; i <= 5; i++) begin
            chk("id_dc", FRZ, S_DC);
            tick();
        end
        dcache_miss = 1'b0; dcache_ready = 1'b1;
        chk("id_t6", STALL, S_DC);
        tick();
        dcache_ready = 1'b0;
        chk("id_t7", STALL, S_IC);
        tick();
        chk("id_t8", STALL, S_IC);
        tick();
        icache_ready = 1'b1;
        chk("id_t9", DEF, S_IC);
        tick();
        idle();
        chk("id_t10", DEF, S_RUN);
        tick();

        // mispredict beats load-use and I-miss; mispredict inside IC_WAIT
        EX_mispredict = 1'b1; icache_miss = 1'b1;
        EX_mem_read = 1'b1; EX_dest_reg = 5'd9; ID_rs = 5'd9;
        chk("mp_run", MISP, S_RUN);
        tick();
        idle();
        icache_miss = 1'b1;
        chk("mp_stay", STALL, S_RUN);
        tick();
        EX_mispredict = 1'b1;
        chk("mp_ic", ICMP, S_IC);
        tick();
        EX_mispredict = 1'b0;
        chk("mp_ic_hold", STALL, S_IC);
        icache_ready = 1'b1;
        chk("mp_ic_rdy", DEF, S_IC);
        tick();
        idle();
        chk("mp_ic_run", DEF, S_RUN);
        tick();

        // reset in DC_WAIT with pend_flush set: no FLUSH_PEND afterwards
        dcache_miss = 1'b1; EX_mispredict = 1'b1;
        chk("rdc_c1", FRZ, S_RUN);
        tick();
        EX_mispredict = 1'b0;
        chk("rdc_w1", FRZ, S_DC);
        tick();
        rst = 1'b1;
        chk("rdc_rst", RSTV, S_DC);
        tick();
        rst = 1'b0; dcache_miss = 1'b0;
        chk("rdc_after", DEF, S_RUN);
        tick();
        dcache_miss = 1'b1;
        tick();
        dcache_miss = 1'b0; dcache_ready = 1'b1;
        chk("rdc_ready", DEF, S_DC);
        tick();
        idle();
        chk("rdc_nofp", DEF, S_RUN);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
